// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix loader and the determinant engine:
// matrix geometry, flattened bus width, fill counter width and the
// 2-bit controller state encoding.
package matrix_pkg;

  // Matrix geometry (square matrix of signed two's-complement entries)
  localparam int DIM     = 8;
  localparam int ENTRY_W = 8;
  localparam int NUM_ENT = DIM * DIM;
  localparam int FLAT_W  = DIM * DIM * ENTRY_W;

  // Fill counter must hold 0..NUM_ENT inclusive
  localparam int CNT_W   = 7;

  // Controller states; the encoding is shared with the determinant engine
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // MSB position of entry k inside a flattened bus of flat_w bits.
  // Entry 0 sits at the top of the bus so the hex dump reads row-major.
  function automatic int entry_msb(input int k, input int flat_w, input int entry_w);
    return flat_w - 1 - (k * entry_w);
  endfunction

endpackage

// File: rtl/matrix_loader.sv
// Matrix loader: collects DIM*DIM signed entries in row-major order into a
// flattened register bus, then hands the matrix to the determinant engine
// with a Start/Done/Ack handshake. The bus is frozen while the engine works.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int DIM     = matrix_pkg::DIM,
  parameter int ENTRY_W = matrix_pkg::ENTRY_W
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic signed [ENTRY_W-1:0]        Entry_Data,
  input  logic                             Entry_Valid,
  output logic                             Entry_Ready,
  input  logic                             Clear,
  input  logic                             Det_Done,
  output logic                             Start,
  output logic                             Ack,
  output logic [DIM*DIM*ENTRY_W-1:0]       input_arr_flat,
  output logic [CNT_W-1:0]                 Fill_Count,
  output logic                             q_Fill,
  output logic                             q_Start,
  output logic                             q_Wait,
  output logic                             q_Ack
);

  localparam int N_ENT  = DIM * DIM;
  localparam int FLAT_L = DIM * DIM * ENTRY_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ENT - 1);

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   fill_count_reg;
  logic               start_reg;
  logic               ack_reg;
  logic [ENTRY_W-1:0] entry_reg [N_ENT];

  // An entry is taken only in FILL; Clear wins over a simultaneous valid
  logic accept;
  logic clear_fill;
  assign accept     = (state_reg == ST_FILL) && Entry_Valid && !Clear;
  assign clear_fill = (state_reg == ST_FILL) && Clear;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: last accepted entry launches the engine, Done is
  // honoured only while waiting, START and ACK are single-cycle states
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FILL: begin
        if (accept && (fill_count_reg == LAST_IDX)) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (Det_Done) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        state_next = ST_FILL;
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

  // Decoded outputs: ready and one-hot flags follow the state register
  always_comb begin
    Entry_Ready = 1'b0;
    q_Fill      = 1'b0;
    q_Start     = 1'b0;
    q_Wait      = 1'b0;
    q_Ack       = 1'b0;
    case (state_reg)
      ST_FILL: begin
        Entry_Ready = 1'b1;
        q_Fill      = 1'b1;
      end
      ST_START: q_Start = 1'b1;
      ST_WAIT:  q_Wait  = 1'b1;
      ST_ACK:   q_Ack   = 1'b1;
      default: begin
        Entry_Ready = 1'b1;
        q_Fill      = 1'b1;
      end
    endcase
  end

  // Registered handshake pulses: asserted for the cycle spent in START/ACK.
  // Loading them from state_next keeps them aligned with the state flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      start_reg <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      start_reg <= (state_next == ST_START);
      ack_reg   <= (state_next == ST_ACK);
    end
  end

  assign Start = start_reg;
  assign Ack   = ack_reg;

  // Fill counter: counts accepted entries, zeroed by Clear and when the
  // handshake completes so the next fill starts again at index 0
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fill_count_reg <= '0;
    end else if (clear_fill) begin
      fill_count_reg <= '0;
    end else if (accept) begin
      fill_count_reg <= fill_count_reg + CNT_W'(1);
    end else if (state_reg == ST_ACK) begin
      fill_count_reg <= '0;
    end
  end

  assign Fill_Count = fill_count_reg;

  // One register per entry; the fill counter is the write address. Writes
  // can only happen in FILL, so the bus is frozen through START..ACK. Old
  // entries survive the return to FILL and are simply overwritten.
  generate
    for (genvar gi = 0; gi < N_ENT; gi++) begin : g_entry
      // Entry gi: cleared by reset/Clear, loaded when it is the write target
      always_ff @(posedge Clk) begin
        if (Reset || clear_fill) begin
          entry_reg[gi] <= '0;
        end else if (accept && (fill_count_reg == CNT_W'(gi))) begin
          entry_reg[gi] <= Entry_Data;
        end
      end

      assign input_arr_flat[entry_msb(gi, FLAT_L, ENTRY_W) -: ENTRY_W] = entry_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: loads matrices, checks the flattened
// bus against a scoreboard at every Start pulse and exercises the
// handshake, Clear, reset and gapped-input behaviour.
module tb_matrix_loader;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [7:0]   Entry_Data;
  logic         Entry_Valid;
  logic         Entry_Ready;
  logic         Clear;
  logic         Det_Done;
  logic         Start;
  logic         Ack;
  logic [511:0] input_arr_flat;
  logic [6:0]   Fill_Count;
  logic         q_Fill, q_Start, q_Wait, q_Ack;

  int           tests = 0;
  int           fails = 0;
  logic [511:0] model_flat;
  int           model_cnt;
  logic [511:0] exp_q [$];
  logic [7:0]   mat [64];
  int           txn = 0;

  always #5 Clk = ~Clk;

  matrix_loader dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Entry_Data     (Entry_Data),
    .Entry_Valid    (Entry_Valid),
    .Entry_Ready    (Entry_Ready),
    .Clear          (Clear),
    .Det_Done       (Det_Done),
    .Start          (Start),
    .Ack            (Ack),
    .input_arr_flat (input_arr_flat),
    .Fill_Count     (Fill_Count),
    .q_Fill         (q_Fill),
    .q_Start        (q_Start),
    .q_Wait         (q_Wait),
    .q_Ack          (q_Ack)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] exp_flags);
    check(tag, {q_Fill, q_Start, q_Wait, q_Ack}, exp_flags);
  endtask

  // Accept n entries from mat[] starting at the model's current index
  task automatic load_n(input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        Entry_Valid = 1'b0;
        Entry_Data  = 8'hAA;
        step();
        check("gap_hold", Fill_Count, model_cnt);
      end
      Entry_Valid = 1'b1;
      Entry_Data  = mat[model_cnt];
      step();
      model_flat[511 - 8*model_cnt -: 8] = mat[model_cnt];
      model_cnt++;
      check("fill_count", Fill_Count, model_cnt);
      check("start_flag", Start, (model_cnt == 64));
    end
    Entry_Valid = 1'b0;
  endtask

  // Full load: push expectation, then compare it at the Start pulse
  task automatic load_full(input bit gap);
    load_n(64 - model_cnt, gap);
    exp_q.push_back(model_flat);
    check("start_pulse", Start, 1'b1);
    check_state("in_start", 4'b0100);
    check("start_not_ready", Entry_Ready, 1'b0);
    if (exp_q.size() > 0) check("flat_at_start", input_arr_flat, exp_q.pop_front());
    txn++;
    $display("[TB] txn %0d: matrix loaded, Start seen, flat[511:504]=%02h flat[7:0]=%02h",
             txn, input_arr_flat[511:504], input_arr_flat[7:0]);
  endtask

  // From START: hold Done low for `hold` cycles, then complete the handshake
  task automatic finish_txn(input int hold);
    int budget;
    Det_Done = 1'b0;
    step();
    check_state("to_wait", 4'b0010);
    check("start_one_cycle", Start, 1'b0);
    for (int i = 0; i < hold; i++) begin
      Entry_Valid = 1'b1;
      Entry_Data  = 8'h33;
      Clear       = (i % 2 == 0);
      step();
      check_state("wait_hold", 4'b0010);
      check("wait_no_ack", Ack, 1'b0);
      check("wait_flat_stable", input_arr_flat, model_flat);
    end
    Entry_Valid = 1'b0;
    Clear       = 1'b0;
    Det_Done    = 1'b1;
    budget      = 0;
    do begin
      step();
      budget++;
    end while (!Ack && budget < 5);
    check("ack_seen", Ack, 1'b1);
    check("ack_cycles", budget, 1);
    check("ack_no_start", Start, 1'b0);
    check_state("in_ack", 4'b0001);
    check("ack_flat_stable", input_arr_flat, model_flat);
    Det_Done = 1'b0;
    step();
    check("ack_one_cycle", Ack, 1'b0);
    check_state("back_fill", 4'b1000);
    check("count_zero_after_ack", Fill_Count, 0);
    check("flat_kept_after_ack", input_arr_flat, model_flat);
    model_cnt = 0;
    $display("[TB] txn %0d: handshake complete", txn);
  endtask

  initial begin
    Reset       = 1'b1;
    Entry_Data  = '0;
    Entry_Valid = 1'b0;
    Clear       = 1'b0;
    Det_Done    = 1'b0;
    model_flat  = '0;
    model_cnt   = 0;

    // Reset state
    step();
    step();
    Reset = 1'b0;
    check_state("reset_state", 4'b1000);
    check("reset_ready", Entry_Ready, 1'b1);
    check("reset_count", Fill_Count, 0);
    check("reset_flat", input_arr_flat, '0);
    check("reset_start", Start, 1'b0);
    check("reset_ack", Ack, 1'b0);

    // Identity matrix, Entry_Valid held high; Done high in FILL is ignored
    for (int k = 0; k < 64; k++) mat[k] = ((k / 8) == (k % 8)) ? 8'h01 : 8'h00;
    Det_Done = 1'b1;
    load_full(1'b0);
    for (int d = 0; d < 8; d++) check("ident_diag", input_arr_flat[511 - 72*d -: 8], 8'h01);
    finish_txn(20);

    // Clear mid-fill with a simultaneous valid entry
    for (int k = 0; k < 64; k++) mat[k] = 8'h7F;
    load_n(10, 1'b0);
    Clear       = 1'b1;
    Entry_Valid = 1'b1;
    Entry_Data  = 8'h55;
    step();
    Clear       = 1'b0;
    Entry_Valid = 1'b0;
    model_flat  = '0;
    model_cnt   = 0;
    check("clear_count", Fill_Count, 0);
    check("clear_flat", input_arr_flat, '0);
    check_state("clear_state", 4'b1000);
    for (int k = 0; k < 64; k++) mat[k] = 8'($urandom_range(0, 255));
    load_full(1'b0);
    finish_txn(0);

    // Negative entries at both ends
    for (int k = 0; k < 64; k++) mat[k] = 8'($urandom_range(0, 255));
    mat[0]  = 8'hFE;
    mat[63] = 8'h80;
    load_full(1'b0);
    check("neg_first", input_arr_flat[511:504], 8'hFE);
    check("neg_last", input_arr_flat[7:0], 8'h80);
    finish_txn(2);

    // Reset at Fill_Count=30 with a valid entry pending
    for (int k = 0; k < 64; k++) mat[k] = 8'($urandom_range(1, 255));
    load_n(30, 1'b0);
    Reset       = 1'b1;
    Entry_Valid = 1'b1;
    step();
    Reset       = 1'b0;
    Entry_Valid = 1'b0;
    model_flat  = '0;
    model_cnt   = 0;
    check("rst_fill_count", Fill_Count, 0);
    check("rst_fill_flat", input_arr_flat, '0);
    check_state("rst_fill_state", 4'b1000);
    check("rst_fill_start", Start, 1'b0);

    // Reset while waiting for Done, with Done asserted
    load_full(1'b0);
    step();
    check_state("pre_rst_wait", 4'b0010);
    Reset    = 1'b1;
    Det_Done = 1'b1;
    step();
    Reset    = 1'b0;
    Det_Done = 1'b0;
    model_flat = '0;
    model_cnt  = 0;
    check_state("rst_wait_state", 4'b1000);
    check("rst_wait_ack", Ack, 1'b0);
    check("rst_wait_start", Start, 1'b0);
    check("rst_wait_flat", input_arr_flat, '0);
    check("rst_wait_count", Fill_Count, 0);
    step();
    check("rst_wait_no_late_ack", Ack, 1'b0);

    // Gapped input: valid every other cycle
    for (int k = 0; k < 64; k++) mat[k] = 8'($urandom_range(0, 255));
    load_full(1'b1);
    finish_txn(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter DIM, default 8, matrix dimension (rows = columns).
REQ-002 Parameter ENTRY_W, default 8, width of one signed two's-complement entry.
REQ-003 Port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port Reset  input  1  synchronous, active-high reset.
REQ-005 Port Entry_Data  input  ENTRY_W  signed matrix entry, row-major order.
REQ-006 Port Entry_Valid  input  1  Entry_Data valid this cycle.
REQ-007 Port Entry_Ready  output  1  loader accepts an entry this cycle.
REQ-008 Port Clear  input  1  discard partial matrix, restart fill.
REQ-009 Port Det_Done  input  1  downstream determinant engine is in its Done state.
REQ-010 Port Start  output  1  one-cycle start pulse to the determinant engine.
REQ-011 Port Ack  output  1  one-cycle acknowledge to the determinant engine.
REQ-012 Port input_arr_flat  output  DIM*DIM*ENTRY_W (512)  flattened matrix.
REQ-013 Port Fill_Count  output  7  number of entries accepted in the current fill (0..64).
REQ-014 Port q_Fill, q_Start, q_Wait, q_Ack  output  1 each  one-hot state flags.

Function
REQ-015 States: FILL, START, WAIT, ACK; exactly one q_* flag high at all times.
REQ-016 Entry_Ready SHALL equal 1 in FILL and 0 in every other state.
REQ-017 Entry accepted on a rising edge when FILL, Entry_Valid=1 and Clear=0; Fill_Count increments by 1.
REQ-018 Entry k (k = 0..63) SHALL be written to row k/8, column k%8, at bits [511-8k : 504-8k]; entry 0 occupies MSBs.
REQ-019 Entry write latency: one cycle; the updated input_arr_flat is visible on the cycle after acceptance.
REQ-020 Acceptance of entry 63 SHALL transition FILL -> START; Fill_Count reads 64.
REQ-021 START lasts exactly one cycle with Start=1, then transitions to WAIT unconditionally.
REQ-022 WAIT holds until Det_Done=1 is sampled, then transitions to ACK.
REQ-023 ACK lasts exactly one cycle with Ack=1, then returns to FILL with Fill_Count=0.
REQ-024 input_arr_flat SHALL remain bit-stable from entering START through leaving ACK; entries are not cleared on return to FILL, only overwritten.
REQ-025 Clear=1 in FILL: Fill_Count -> 0 and input_arr_flat -> 0 next cycle; any simultaneous Entry_Valid is ignored.
REQ-026 Clear is ignored in START, WAIT and ACK.
REQ-027 Entry_Valid outside FILL SHALL be ignored with no state change.
REQ-028 Det_Done high while in FILL or START SHALL be ignored.
REQ-029 Start and Ack SHALL never be high in the same cycle.

Reset
REQ-030 Reset=1 on a rising edge: state -> FILL, Fill_Count -> 0, input_arr_flat -> 0, Start -> 0, Ack -> 0, Entry_Ready -> 1 from the next cycle.
REQ-031 Reset SHALL override every other input, including mid-fill and mid-WAIT; no Start or Ack pulse is emitted due to reset.

Structure
REQ-032 Shared package matrix_pkg holds DIM, ENTRY_W, FLAT_W = DIM*DIM*ENTRY_W and the 2-bit state encoding; the determinant engine imports the same package.
REQ-033 Single module; no sub-module, since index counter and write decode are one datapath.
REQ-034 All outputs registered except Entry_Ready and q_* flags, which are decoded from the state register.

Verification
REQ-035 Identity: 64 entries (1 on diagonal, else 0), Entry_Valid held high -> Start pulse on cycle 65, flat = 0x01 at bits [511:504], [439:432], ..., [7:0].
REQ-036 Handshake: after Start, hold Det_Done=0 for 20 cycles -> stays WAIT, Ack=0; raise Det_Done -> Ack high exactly one cycle, then FILL with Fill_Count=0.
REQ-037 Clear: load 10 entries of 0x7F, Clear with Entry_Valid=1 -> Fill_Count=0, flat=0; next 64 entries load from index 0.
REQ-038 Negative entries: entry 0 = 0xFE (-2), entry 63 = 0x80 (-128) -> bits [511:504]=0xFE, [7:0]=0x80.
REQ-039 Reset mid-operation: Reset at Fill_Count=30 and again in WAIT -> FILL, flat=0, no Start/Ack pulse.
REQ-040 Gapped input: Entry_Valid toggled every other cycle -> only valid cycles counted; Start after exactly 64 acceptances.
